// File: rtl/layer_mac_sequencer.sv
// Address and phase sequencer for one fully connected layer: clear, N_IN MACs, bias, write-back
// per neuron, then a single-cycle done pulse.
module layer_mac_sequencer #(
  parameter int unsigned N_IN    = 62,
  parameter int unsigned N_OUT   = 30,
  parameter int unsigned IN_W    = 6,
  parameter int unsigned OUT_W   = 5,
  parameter int unsigned WADDR_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [IN_W-1:0]    in_addr,
  output logic [WADDR_W-1:0] w_addr,
  output logic               addr_vld,
  output logic               mac_clr,
  output logic               mac_en,
  output logic               bias_en,
  output logic [OUT_W-1:0]   bias_addr,
  output logic               out_wr,
  output logic [OUT_W-1:0]   out_addr,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StDrain,
    StBias,
    StWrite,
    StDone
  } state_e;

  localparam logic [IN_W-1:0]  InLast  = IN_W'(N_IN - 1);
  localparam logic [OUT_W-1:0] OutLast = OUT_W'(N_OUT - 1);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    i_q, i_d;
  logic [OUT_W-1:0]   j_q, j_d;
  logic [WADDR_W-1:0] w_q, w_d;
  logic               mac_en_q, mac_en_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      w_q      <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      w_q      <= w_d;
      mac_en_q <= mac_en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    w_d      = w_q;
    // Memory read latency is one cycle, so the accumulate enable trails addr_vld.
    mac_en_d = (state_q == StAccum) && !abort;

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      i_d     = '0;
      j_d     = '0;
      w_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StClear;
            i_d     = '0;
            j_d     = '0;
            w_d     = '0;
          end
        end
        StClear: state_d = StAccum;
        StAccum: begin
          // Hold the weight address on the very last read so it never passes N_IN*N_OUT-1.
          if (!((i_q == InLast) && (j_q == OutLast))) begin
            w_d = w_q + WADDR_W'(1);
          end
          if (i_q == InLast) begin
            i_d     = '0;
            state_d = StDrain;
          end else begin
            i_d = i_q + IN_W'(1);
          end
        end
        StDrain: state_d = StBias;
        StBias:  state_d = StWrite;
        StWrite: begin
          if (j_q == OutLast) begin
            state_d = StDone;
          end else begin
            j_d     = j_q + OUT_W'(1);
            state_d = StClear;
          end
        end
        StDone: begin
          state_d = StIdle;
          j_d     = '0;
          w_d     = '0;
        end
        default: begin
          state_d = StIdle;
          i_d     = '0;
          j_d     = '0;
          w_d     = '0;
        end
      endcase
    end
  end

  // Counters rest at zero outside their active phases, so addresses drive straight out.
  always_comb begin
    in_addr   = i_q;
    w_addr    = w_q;
    bias_addr = j_q;
    out_addr  = j_q;
    mac_en    = mac_en_q;
    addr_vld  = (state_q == StAccum);
    mac_clr   = (state_q == StClear);
    bias_en   = (state_q == StBias);
    out_wr    = (state_q == StWrite);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
  end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Directed bench for layer_mac_sequencer with N_IN=4, N_OUT=3 (8 cycles per neuron, done at 25).
module tb_layer_mac_sequencer;

  localparam int N_IN    = 4;
  localparam int N_OUT   = 3;
  localparam int IN_W    = 6;
  localparam int OUT_W   = 5;
  localparam int WADDR_W = 11;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic [IN_W-1:0]    in_addr;
  logic [WADDR_W-1:0] w_addr;
  logic               addr_vld;
  logic               mac_clr;
  logic               mac_en;
  logic               bias_en;
  logic [OUT_W-1:0]   bias_addr;
  logic               out_wr;
  logic [OUT_W-1:0]   out_addr;
  logic               busy;
  logic               done;

  int n_cmp;
  int n_err;
  int cyc;
  int n, p;
  int cnt_clr, cnt_mac, cnt_bias, cnt_wr, cnt_done;
  logic e_vld, e_clr, e_mac, e_bias, e_wr, e_done, e_busy;

  layer_mac_sequencer #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .WADDR_W(WADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_addr  (in_addr),
    .w_addr   (w_addr),
    .addr_vld (addr_vld),
    .mac_clr  (mac_clr),
    .mac_en   (mac_en),
    .bias_en  (bias_en),
    .bias_addr(bias_addr),
    .out_wr   (out_wr),
    .out_addr (out_addr),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Applies start for one sampling edge; on return the DUT is in cycle 1.
  task automatic start_layer();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".in_addr"},   32'(in_addr),   0);
    check_eq({tag, ".w_addr"},    32'(w_addr),    0);
    check_eq({tag, ".addr_vld"},  32'(addr_vld),  0);
    check_eq({tag, ".mac_clr"},   32'(mac_clr),   0);
    check_eq({tag, ".mac_en"},    32'(mac_en),    0);
    check_eq({tag, ".bias_en"},   32'(bias_en),   0);
    check_eq({tag, ".bias_addr"}, 32'(bias_addr), 0);
    check_eq({tag, ".out_wr"},    32'(out_wr),    0);
    check_eq({tag, ".out_addr"},  32'(out_addr),  0);
    check_eq({tag, ".busy"},      32'(busy),      0);
    check_eq({tag, ".done"},      32'(done),      0);
  endtask

  // Steps from cycle c0 until done is seen, bounded; reports the cycle it appeared in.
  task automatic wait_done(input string tag, input int c0);
    int c;
    c = c0;
    while (!done && c < 200) begin
      step();
      c++;
    end
    check_eq({tag, ".done_cycle"}, 32'(c), 25);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b1;
    step();
    check_eq("idle.busy", 32'(busy), 0);

    // Full layer: timing, address sequence and phase order against a cycle-arithmetic model.
    cnt_clr = 0; cnt_mac = 0; cnt_bias = 0; cnt_wr = 0; cnt_done = 0;
    start_layer();
    for (int c = 1; c <= 26; c++) begin
      e_vld = 0; e_clr = 0; e_mac = 0; e_bias = 0; e_wr = 0;
      e_busy = (c <= 25);
      e_done = (c == 25);
      n = (c - 1) / 8;
      p = (c - 1) % 8;
      if (c <= 24) begin
        e_clr  = (p == 0);
        e_vld  = (p >= 1) && (p <= 4);
        e_mac  = (p >= 2) && (p <= 5);
        e_bias = (p == 6);
        e_wr   = (p == 7);
      end
      check_eq($sformatf("run.busy@%0d", c),     32'(busy),     32'(e_busy));
      check_eq($sformatf("run.done@%0d", c),     32'(done),     32'(e_done));
      check_eq($sformatf("run.clr@%0d", c),      32'(mac_clr),  32'(e_clr));
      check_eq($sformatf("run.vld@%0d", c),      32'(addr_vld), 32'(e_vld));
      check_eq($sformatf("run.mac_en@%0d", c),   32'(mac_en),   32'(e_mac));
      check_eq($sformatf("run.bias_en@%0d", c),  32'(bias_en),  32'(e_bias));
      check_eq($sformatf("run.out_wr@%0d", c),   32'(out_wr),   32'(e_wr));
      if (e_vld) begin
        check_eq($sformatf("run.in_addr@%0d", c), 32'(in_addr), 32'(p - 1));
        check_eq($sformatf("run.w_addr@%0d", c),  32'(w_addr),  32'(n * 4 + p - 1));
      end
      if (e_bias) check_eq($sformatf("run.bias_addr@%0d", c), 32'(bias_addr), 32'(n));
      if (e_wr)   check_eq($sformatf("run.out_addr@%0d", c),  32'(out_addr),  32'(n));
      cnt_clr  += int'(mac_clr);
      cnt_mac  += int'(mac_en);
      cnt_bias += int'(bias_en);
      cnt_wr   += int'(out_wr);
      cnt_done += int'(done);
      step();
    end
    check_eq("run.n_clr",  32'(cnt_clr),  3);
    check_eq("run.n_mac",  32'(cnt_mac),  12);
    check_eq("run.n_bias", 32'(cnt_bias), 3);
    check_eq("run.n_wr",   32'(cnt_wr),   3);
    check_eq("run.n_done", 32'(cnt_done), 1);

    // Start held high: no restart while busy, next layer begins after the post-done IDLE cycle.
    cnt_wr = 0;
    start  = 1'b1;
    step();
    for (int c = 1; c <= 27; c++) begin
      check_eq($sformatf("hold.busy@%0d", c), 32'(busy), (c == 26) ? 0 : 1);
      check_eq($sformatf("hold.done@%0d", c), 32'(done), (c == 25) ? 1 : 0);
      if (c == 24) check_eq("hold.out_addr@24", 32'(out_addr), 2);
      if (c == 27) check_eq("hold.clr@27", 32'(mac_clr), 1);
      if (c <= 25) cnt_wr += int'(out_wr);
      if (c < 27) step();
    end
    check_eq("hold.n_wr", 32'(cnt_wr), 3);
    start = 1'b0;
    abort = 1'b1;
    step();
    check_eq("hold.abort.busy", 32'(busy), 0);
    step();
    check_eq("idle_abort.busy", 32'(busy), 0);
    check_eq("idle_abort.done", 32'(done), 0);
    abort = 1'b0;

    // Abort in the second ACCUM cycle of neuron 1 (cycle 11).
    start_layer();
    for (int c = 1; c < 11; c++) step();
    check_eq("abort.vld@11",     32'(addr_vld), 1);
    check_eq("abort.w_addr@11",  32'(w_addr),   5);
    check_eq("abort.in_addr@11", 32'(in_addr),  1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort.busy",   32'(busy),   0);
    check_eq("abort.mac_en", 32'(mac_en), 0);
    check_eq("abort.w_addr", 32'(w_addr), 0);
    check_eq("abort.out_wr", 32'(out_wr), 0);
    cnt_wr = 0; cnt_done = 0;
    for (int c = 0; c < 20; c++) begin
      cnt_wr   += int'(out_wr);
      cnt_done += int'(done);
      step();
    end
    check_eq("abort.n_wr",   32'(cnt_wr),   0);
    check_eq("abort.n_done", 32'(cnt_done), 0);
    start_layer();
    check_eq("restart.clr@1", 32'(mac_clr), 1);
    step();
    check_eq("restart.vld@2",    32'(addr_vld), 1);
    check_eq("restart.w_addr@2", 32'(w_addr),   0);
    wait_done("restart", 2);
    step();

    // Synchronous reset during BIAS of neuron 0 (cycle 7).
    start_layer();
    for (int c = 1; c < 7; c++) step();
    check_eq("rst.bias_en@7", 32'(bias_en), 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_all_zero("midrst");
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq($sformatf("midrst.idle%0d", c), 32'(busy), 0);
    end
    start_layer();
    wait_done("postrst", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/layer_mac_sequencer.md
Name: layer_mac_sequencer

Overview:
- Sequences one fully connected layer (hidden layer 1, hidden layer 2 or output) of the neural network datapath.
- On `start`, it walks every output neuron through four phases: clear accumulator, N_IN multiply-accumulates, bias add, activation/write-back.
- It drives the input-buffer and weight-memory addresses, and the MAC/bias/activation enables.
- It pulses `done` back to the top-level network controller.

Parameters:
- N_IN, 62, inputs per neuron (MAC steps per neuron); legal range 1..2^IN_W.
- N_OUT, 30, neurons in the layer; legal range 1..2^OUT_W.
- IN_W, 6, width of in_addr.
- OUT_W, 5, width of out_addr / bias_addr.
- WADDR_W, 11, width of w_addr; must satisfy 2^WADDR_W >= N_IN*N_OUT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset; sampled on the rising clk edge, 0 = reset.
- start  in  1  begin layer; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next edge, no done.
- in_addr  out  IN_W  input-buffer read address.
- w_addr  out  WADDR_W  weight-memory read address, row-major: neuron*N_IN + input.
- addr_vld  out  1  in_addr/w_addr valid this cycle.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate memory data; equals addr_vld delayed by one cycle (memory read latency 1).
- bias_en  out  1  add bias[bias_addr] to accumulator.
- bias_addr  out  OUT_W  current neuron index.
- out_wr  out  1  write activated accumulator to out_addr.
- out_addr  out  OUT_W  current neuron index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the layer completes.

Behaviour:
- All outputs are registered or decoded from registered state.
- While rst=0 at a clk edge: state=IDLE, i=0, j=0, w_addr=0. All enables, addr_vld, mac_en, busy and done are 0; address outputs are 0.

States and transitions:
- IDLE: start=1 -> CLEAR, with i=0, j=0, w_addr=0. Otherwise stay.
- CLEAR: mac_clr=1. -> ACCUM.
- ACCUM: addr_vld=1, in_addr=i, w_addr = running counter.
  - Each cycle: i++ and w_addr++.
  - When i==N_IN-1: -> DRAIN, and i resets to 0. Lasts exactly N_IN cycles.
- DRAIN: addr_vld=0. mac_en=1 for the final operand. -> BIAS.
- BIAS: bias_en=1, bias_addr=j. -> WRITE.
- WRITE: out_wr=1, out_addr=j.
  - If j==N_OUT-1: -> DONE.
  - Else j++ and -> CLEAR. w_addr keeps counting, so no multiply is needed.
- DONE: done=1, busy=1. -> IDLE. j and w_addr reset to 0.

Timing:
- mac_en is high for exactly N_IN consecutive cycles per neuron: first ACCUM cycle+1 through DRAIN.
- Per-neuron cost is N_IN+4 cycles.
- Latency from the start-sampling edge to the done pulse is N_OUT*(N_IN+4) cycles. Done is high during the cycle numbered N_OUT*(N_IN+4)+1 after start.

Boundary conditions:
- start while busy: ignored.
- start in the same cycle as DONE: ignored; start is accepted the next cycle from IDLE.
- abort in any non-IDLE state: -> IDLE at the next edge, counters cleared.
  - mac_en is forced to 0 in that next cycle.
  - out_wr and done are not asserted.
  - abort has priority over start and over normal transitions.
- abort in IDLE: no effect.
- N_IN=1: ACCUM lasts one cycle.
- N_OUT=1: WRITE goes directly to DONE.
- Counters never exceed N_IN-1 or N_OUT-1. w_addr peaks at N_IN*N_OUT-1 and never wraps within a layer.
- rst=0 mid-operation behaves like abort but also zeroes all outputs in the same edge.

Test Plan:
- N_IN=4, N_OUT=3, start pulse at cycle 0.
  - Required: done high exactly at cycle 25.
  - out_wr pulses at cycles 8, 16, 24 with out_addr 0, 1, 2.
  - busy high cycles 1-25.
- Same configuration, address sequence check.
  - Required: w_addr with addr_vld=1 reads 0,1,2,3 | 4,5,6,7 | 8,9,10,11; in_addr reads 0-3 repeated.
  - mac_en is the 1-cycle-delayed copy of addr_vld, with 12 high cycles total.
- Phase ordering check.
  - Required: mac_clr, bias_en and out_wr each pulse exactly 3 times, in the order clr -> 4×mac_en -> bias_en -> out_wr per neuron.
  - bias_addr equals out_addr equals the neuron index.
- start held high continuously.
  - Required: a second layer begins the cycle after done's IDLE cycle.
  - The first layer's latency is unchanged; extra start pulses while busy cause no restart.
- abort asserted in the second ACCUM cycle of neuron 1.
  - Required: IDLE next cycle, busy=0, no further out_wr, done never asserted.
  - A new start then yields w_addr restarting at 0.
- rst=0 for one edge mid-BIAS.
  - Required: all outputs 0 the following cycle.
  - The sequencer stays in IDLE until start, and a full run then completes in 25 cycles.
